r4_issue_ctrl: RTL and testbench

//  Issue and occupancy controller for the fused multiply-add (R4) pipeline, covering FMADD/FMSUB/FNMADD/FNMSUB.

---
 rtl/r4_issue_ctrl.sv | 91 +++++++++
 tb/tb_r4_issue_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r4_issue_ctrl.sv
// Issue/occupancy controller for the fused multiply-add (R4) pipeline.
// Tracks a shadow copy of every R4 stage to drive stall, clear and RAW-hazard decisions.
module r4_issue_ctrl #(
  parameter  int ADDR_WIDTH = 5,
  parameter  int DEPTH      = 6,
  localparam int OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [ADDR_WIDTH-1:0] issue_rd_i,
  input  logic                  issue_rw_i,
  input  logic                  issue_fprw_i,
  input  logic [ADDR_WIDTH-1:0] rs1_i,
  input  logic [ADDR_WIDTH-1:0] rs2_i,
  input  logic [ADDR_WIDTH-1:0] rs3_i,
  input  logic                  wb_ready_i,
  input  logic                  flush_i,
  input  logic [DEPTH-1:0]      kill_i,
  output logic                  en_o,
  output logic [DEPTH-1:0]      clear_o,
  output logic                  p_signal_o,
  output logic                  wb_valid_o,
  output logic [ADDR_WIDTH-1:0] wb_rd_o,
  output logic                  wb_rw_o,
  output logic                  wb_fprw_o,
  output logic                  hazard_o,
  output logic [OCC_W-1:0]      occupancy_o
);

  typedef struct packed {
    logic                  v;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  rw;
    logic                  fprw;
  } stage_t;

  stage_t [DEPTH-1:0] stage_q, stage_d;

  // The whole pipe freezes while the oldest result waits for the writeback port.
  assign en_o          = ~(stage_q[DEPTH-1].v & ~wb_ready_i);
  assign clear_o       = kill_i | {DEPTH{flush_i}};
  assign issue_ready_o = en_o & ~hazard_o & ~flush_i;
  assign p_signal_o    = issue_valid_i & issue_ready_o;

  assign wb_valid_o = stage_q[DEPTH-1].v & ~clear_o[DEPTH-1];
  assign wb_rd_o    = stage_q[DEPTH-1].rd;
  assign wb_rw_o    = stage_q[DEPTH-1].rw;
  assign wb_fprw_o  = stage_q[DEPTH-1].fprw;

  // Conservative: the retiring stage also counts, so a dependent op waits one extra cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    hazard_o = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (stage_q[k].v && stage_q[k].fprw &&
          (stage_q[k].rd == rs1_i || stage_q[k].rd == rs2_i || stage_q[k].rd == rs3_i))
        hazard_o = 1'b1;
    end
  end

  always_comb begin
    occupancy_o = '0;
    for (int k = 0; k < DEPTH; k++)
      occupancy_o = occupancy_o + OCC_W'(stage_q[k].v);
  end

  always_comb begin
    stage_d = stage_q;
    if (en_o) begin
      stage_d[0] = '{v: p_signal_o, rd: issue_rd_i, rw: issue_rw_i, fprw: issue_fprw_i};
      for (int k = 1; k < DEPTH; k++)
        stage_d[k] = stage_q[k-1];
    end
    // Clear wins over both the shift and the hold.
    for (int k = 0; k < DEPTH; k++)
      if (clear_o[k]) stage_d[k].v = 1'b0;
  end

  // NOTE: the shadow stages are reset in full because their valids gate writeback and hazards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all stages update together.
      stage_q <= stage_d;
    end
  end

endmodule

// File: tb/tb_r4_issue_ctrl.sv
// Self-checking bench for r4_issue_ctrl: scoreboard of accepted ops checked at retirement.
module tb_r4_issue_ctrl;

  localparam int AW    = 5;
  localparam int DEPTH = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             issue_valid_i, issue_ready_o;
  logic [AW-1:0]    issue_rd_i, rs1_i, rs2_i, rs3_i;
  logic             issue_rw_i, issue_fprw_i;
  logic             wb_ready_i, flush_i;
  logic [DEPTH-1:0] kill_i, clear_o;
  logic             en_o, p_signal_o, wb_valid_o, wb_rw_o, wb_fprw_o, hazard_o;
  logic [AW-1:0]    wb_rd_o;
  logic [2:0]       occupancy_o;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic          rw;
    logic          fprw;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  r4_issue_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst_n),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_rd_i(issue_rd_i), .issue_rw_i(issue_rw_i), .issue_fprw_i(issue_fprw_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i),
    .wb_ready_i(wb_ready_i), .flush_i(flush_i), .kill_i(kill_i),
    .en_o(en_o), .clear_o(clear_o), .p_signal_o(p_signal_o),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_rw_o(wb_rw_o), .wb_fprw_o(wb_fprw_o),
    .hazard_o(hazard_o), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  // Retirement monitor: a result retires on the edge after a negedge with wb_valid & wb_ready.
  always @(negedge clk) begin
    if (rst_n && wb_valid_o && wb_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL retire_unexpected: got rd=%0d with empty scoreboard at %0t", wb_rd_o, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({wb_rd_o, wb_rw_o, wb_fprw_o} !== e) begin
          errors++;
          $display("FAIL retire_order: got rd=%0d rw=%0b fprw=%0b expected rd=%0d rw=%0b fprw=%0b",
                   wb_rd_o, wb_rw_o, wb_fprw_o, e.rd, e.rw, e.fprw);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid_i = 1'b0;
    issue_rd_i    = '0;
    issue_rw_i    = 1'b0;
    issue_fprw_i  = 1'b0;
    rs1_i = '0; rs2_i = '0; rs3_i = '0;
    flush_i = 1'b0;
    kill_i  = '0;
  endtask

  // Presents one op for one cycle; checks the handshake and records accepted ops.
  task automatic issue_one(input logic [AW-1:0] rd, input logic rw, input logic fprw,
                           input logic expect_acc);
    issue_valid_i = 1'b1;
    issue_rd_i    = rd;
    issue_rw_i    = rw;
    issue_fprw_i  = fprw;
    @(negedge clk);
    checks++;
    if (issue_ready_o !== expect_acc || p_signal_o !== expect_acc) begin
      errors++;
      $display("FAIL issue_handshake rd=%0d: ready=%0b p_signal=%0b expected %0b",
               rd, issue_ready_o, p_signal_o, expect_acc);
    end
    if (expect_acc) exp_q.push_back('{rd: rd, rw: rw, fprw: fprw});
    step();
    issue_valid_i = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (occupancy_o != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (occupancy_o !== 3'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: occupancy=%0d pending=%0d expected 0/0 within %0d cycles",
               name, occupancy_o, exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    wb_ready_i = 1'b1;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({wb_valid_o, hazard_o, occupancy_o, en_o, issue_ready_o} !== {1'b0, 1'b0, 3'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: wb_valid=%0b hazard=%0b occ=%0d en=%0b ready=%0b expected 0 0 0 1 1",
               wb_valid_o, hazard_o, occupancy_o, en_o, issue_ready_o);
    end
    flush_i = 1'b1;
    #1;
    checks++;
    if (issue_ready_o !== 1'b0 || clear_o !== 6'h3F) begin
      errors++;
      $display("FAIL reset_flush_ready: ready=%0b clear=%h expected 0 3f", issue_ready_o, clear_o);
    end
    flush_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    issue_one(5'd3, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++;
      if (wb_valid_o !== (i == DEPTH - 1) || (i == DEPTH - 1 && wb_rd_o !== 5'd3)) begin
        errors++;
        $display("FAIL single_latency cycle %0d: wb_valid=%0b wb_rd=%0d expected %0b rd 3",
                 i, wb_valid_o, wb_rd_o, i == DEPTH - 1);
      end
      step();
    end
    checks++;
    if (occupancy_o !== 3'd0) begin
      errors++;
      $display("FAIL single_occupancy: got %0d expected 0", occupancy_o);
    end
  endtask

  task automatic test_hazard();
    issue_one(5'd7, 1'b0, 1'b1, 1'b1);
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd9;
    issue_fprw_i  = 1'b1;
    rs2_i         = 5'd7;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      checks++;
      if (hazard_o !== 1'b1 || issue_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL hazard_hold cycle %0d: hazard=%0b ready=%0b expected 1 0", i, hazard_o, issue_ready_o);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (hazard_o !== 1'b0 || issue_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL hazard_release: hazard=%0b ready=%0b expected 0 1", hazard_o, issue_ready_o);
    end
    exp_q.push_back('{rd: 5'd9, rw: 1'b0, fprw: 1'b1});
    step();
    idle_inputs();
    wait_empty("hazard", 20);
  endtask

  task automatic test_back_to_back_stall();
    wb_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      issue_one(AW'(10 + i), 1'(i % 2), 1'b1, 1'b1);
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd20;
    issue_fprw_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (en_o !== 1'b0 || occupancy_o !== 3'd6 || issue_ready_o !== 1'b0 || p_signal_o !== 1'b0 ||
          wb_valid_o !== 1'b1 || wb_rd_o !== 5'd10) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: en=%0b occ=%0d ready=%0b p=%0b wb_valid=%0b wb_rd=%0d expected 0 6 0 0 1 10",
                 i, en_o, occupancy_o, issue_ready_o, p_signal_o, wb_valid_o, wb_rd_o);
      end
      step();
    end
    idle_inputs();
    wb_ready_i = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      checks++;
      if (occupancy_o !== 3'(DEPTH - k)) begin
        errors++;
        $display("FAIL stall_drain step %0d: occupancy=%0d expected %0d", k, occupancy_o, DEPTH - k);
      end
    end
    wait_empty("stall", 4);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++)
      issue_one(AW'(16 + i), 1'b1, 1'b0, 1'b1);
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd20;
    issue_fprw_i  = 1'b1;
    flush_i       = 1'b1;
    @(negedge clk);
    checks++;
    if (clear_o !== 6'h3F || issue_ready_o !== 1'b0 || p_signal_o !== 1'b0 || wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: clear=%h ready=%0b p=%0b wb_valid=%0b expected 3f 0 0 0",
               clear_o, issue_ready_o, p_signal_o, wb_valid_o);
    end
    exp_q.delete();
    step();
    idle_inputs();
    checks++;
    if (occupancy_o !== 3'd0) begin
      errors++;
      $display("FAIL flush_occupancy: got %0d expected 0", occupancy_o);
    end
    repeat (8) step();
  endtask

  task automatic test_kill_stalled();
    wb_ready_i = 1'b0;
    for (int i = 0; i < 3; i++)
      issue_one(AW'(21 + i), 1'b0, 1'b1, 1'b1);
    repeat (3) step();
    @(negedge clk);
    checks++;
    if (en_o !== 1'b0 || wb_valid_o !== 1'b1 || wb_rd_o !== 5'd21) begin
      errors++;
      $display("FAIL kill_pre: en=%0b wb_valid=%0b wb_rd=%0d expected 0 1 21", en_o, wb_valid_o, wb_rd_o);
    end
    step();
    kill_i = 6'b100000;
    @(negedge clk);
    checks++;
    if (wb_valid_o !== 1'b0 || clear_o !== 6'b100000) begin
      errors++;
      $display("FAIL kill_cycle: wb_valid=%0b clear=%b expected 0 100000", wb_valid_o, clear_o);
    end
    void'(exp_q.pop_front());
    step();
    kill_i = '0;
    @(negedge clk);
    checks++;
    if (en_o !== 1'b1 || occupancy_o !== 3'd2 || wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_release: en=%0b occ=%0d wb_valid=%0b expected 1 2 0", en_o, occupancy_o, wb_valid_o);
    end
    step();
    @(negedge clk);
    checks++;
    if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd22 || en_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_advance: wb_valid=%0b wb_rd=%0d en=%0b expected 1 22 0", wb_valid_o, wb_rd_o, en_o);
    end
    step();
    wb_ready_i = 1'b1;
    wait_empty("kill", 10);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++)
      issue_one(AW'(24 + i), 1'b1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (occupancy_o !== 3'd0 || wb_valid_o !== 1'b0 || en_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_async: occ=%0d wb_valid=%0b en=%0b expected 0 0 1", occupancy_o, wb_valid_o, en_o);
    end
    exp_q.delete();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (issue_ready_o !== 1'b1 || occupancy_o !== 3'd0 || wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: ready=%0b occ=%0d wb_valid=%0b expected 1 0 0",
               issue_ready_o, occupancy_o, wb_valid_o);
    end
    repeat (8) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_hazard();
    test_back_to_back_stall();
    test_flush();
    test_kill_stalled();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d ops never retired", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
